// File: rtl/rr_arb_pkg.sv
// Shared types and sizing constants for the 8-way round-robin arbiter.
package rr_arb_pkg;

  localparam int N_REQ  = 8;
  localparam int IDX_W  = 3;
  localparam int HOLD_W = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

endpackage

// File: rtl/prio_enc8.sv
// Fixed-priority encoder over 8 inputs; bit 0 has the highest priority.
module prio_enc8
  import rr_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  output logic [IDX_W-1:0] idx,
  output logic             vld
);

  // NOTE: every always_comb output gets a default before any branch, so no latch is inferred.
  always_comb begin
    idx = '0;
    vld = 1'b0;
    // Walk from the top down so the lowest set bit is the last one written.
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx = IDX_W'(i);
        vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_arbiter_8.sv
// 8-way round-robin arbiter with registered one-hot grant and a hold limit.
module rr_arbiter_8
  import rr_arb_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_id,
  output logic             gnt_vld,
  output logic             timeout
);

  state_t              state, state_nxt;
  logic [IDX_W-1:0]    ptr, ptr_nxt;
  logic [HOLD_W-1:0]   hold_cnt, hold_nxt;
  logic [N_REQ-1:0]    gnt_nxt;
  logic [IDX_W-1:0]    gnt_id_nxt;
  logic                gnt_vld_nxt;
  logic                timeout_nxt;

  logic [2*N_REQ-1:0]  req_dbl;
  logic [N_REQ-1:0]    req_rot;
  logic [IDX_W-1:0]    enc_idx;
  logic                enc_vld;
  logic [IDX_W-1:0]    winner;
  logic                owner_req;
  logic                at_max;

  // Rotate so that bit 0 of the encoder input is requester ptr; the
  // encoder's fixed priority then yields the round-robin search order.
  assign req_dbl = {req, req};
  assign req_rot = req_dbl[ptr +: N_REQ];

  prio_enc8 u_enc (
    .req (req_rot),
    .idx (enc_idx),
    .vld (enc_vld)
  );

  assign winner    = ptr + enc_idx;
  assign owner_req = req[gnt_id];
  assign at_max    = (hold_cnt == HOLD_W'(MAX_HOLD));

  always_comb begin
    state_nxt   = state;
    ptr_nxt     = ptr;
    hold_nxt    = hold_cnt;
    gnt_nxt     = gnt;
    gnt_id_nxt  = gnt_id;
    gnt_vld_nxt = gnt_vld;
    timeout_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (en && enc_vld) begin
          state_nxt   = GRANT;
          gnt_nxt     = N_REQ'(1) << winner;
          gnt_id_nxt  = winner;
          gnt_vld_nxt = 1'b1;
          hold_nxt    = HOLD_W'(1);
        end
      end
      GRANT: begin
        // A dropped request wins over the limit, so timeout only fires
        // when the owner still wants the resource.
        if (!owner_req || at_max) begin
          state_nxt   = IDLE;
          gnt_nxt     = '0;
          gnt_id_nxt  = '0;
          gnt_vld_nxt = 1'b0;
          hold_nxt    = '0;
          ptr_nxt     = gnt_id + IDX_W'(1);
          timeout_nxt = owner_req;
        end else begin
          hold_nxt = hold_cnt + HOLD_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= '0;
      hold_cnt <= '0;
      gnt      <= '0;
      gnt_id   <= '0;
      gnt_vld  <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      hold_cnt <= hold_nxt;
      gnt      <= gnt_nxt;
      gnt_id   <= gnt_id_nxt;
      gnt_vld  <= gnt_vld_nxt;
      timeout  <= timeout_nxt;
    end
  end

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Scoreboard bench for rr_arbiter_8: directed steps queue expected outputs, a monitor compares.
module tb_rr_arbiter_8;

  logic       clk;
  logic       rst;
  logic       en;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] gnt_id;
  logic       gnt_vld;
  logic       timeout;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [7:0] gnt;
    logic [2:0] id;
    logic       to;
    string      name;
  } exp_t;

  exp_t exp_q[$];

  rr_arbiter_8 #(.MAX_HOLD(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .req     (req),
    .gnt     (gnt),
    .gnt_id  (gnt_id),
    .gnt_vld (gnt_vld),
    .timeout (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed view: {gnt, gnt_id, gnt_vld, timeout}.
  task automatic check(input string name, input logic [12:0] act, input logic [12:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got gnt=%h id=%0d vld=%b to=%b, want gnt=%h id=%0d vld=%b to=%b",
               name, act[12:5], act[4:2], act[1], act[0], exp[12:5], exp[4:2], exp[1], exp[0]);
    end
  endtask

  // Monitor: outputs are sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check(e.name, {gnt, gnt_id, gnt_vld, timeout}, {e.gnt, e.id, (e.gnt != 8'h00), e.to});
    end
  end

  // Apply inputs for one cycle, then queue the outputs expected after the edge.
  task automatic step(input logic [7:0] r, input logic e, input logic [7:0] g,
                      input logic [2:0] id, input logic to, input string nm);
    exp_t x;
    req = r;
    en  = e;
    @(posedge clk);
    #1;
    x.gnt  = g;
    x.id   = id;
    x.to   = to;
    x.name = nm;
    exp_q.push_back(x);
  endtask

  task automatic do_reset(input string nm);
    rst = 1'b1;
    #1;
    check(nm, {gnt, gnt_id, gnt_vld, timeout}, 13'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    en  = 1'b0;
    req = 8'h00;
    #2;
    do_reset("reset_initial");

    // Enable gating, then first grant from ptr=0.
    for (int i = 0; i < 10; i++) step(8'hFF, 1'b0, 8'h00, 3'd0, 1'b0, "en_low_no_grant");
    step(8'hFF, 1'b1, 8'h01, 3'd0, 1'b0, "en_high_grant0");
    step(8'h00, 1'b1, 8'h00, 3'd0, 1'b0, "en_release0");

    do_reset("reset_section_a");
    step(8'h81, 1'b1, 8'h01, 3'd0, 1'b0, "basic_grant0");
    step(8'h80, 1'b1, 8'h00, 3'd0, 1'b0, "basic_gap");
    step(8'h80, 1'b1, 8'h80, 3'd7, 1'b0, "basic_grant7");
    step(8'hFF, 1'b1, 8'h80, 3'd7, 1'b0, "hold7_others_ignored");
    step(8'h7F, 1'b1, 8'h00, 3'd0, 1'b0, "release7_gap");
    step(8'hFF, 1'b1, 8'h01, 3'd0, 1'b0, "wrap_grant0");
    step(8'hFF, 1'b0, 8'h01, 3'd0, 1'b0, "grant_ignores_en");
    step(8'h00, 1'b1, 8'h00, 3'd0, 1'b0, "release0");

    // Hold limit 4 with ptr=1: requester 3 held continuously.
    step(8'h08, 1'b1, 8'h08, 3'd3, 1'b0, "hold_c1");
    step(8'h08, 1'b1, 8'h08, 3'd3, 1'b0, "hold_c2");
    step(8'h08, 1'b1, 8'h08, 3'd3, 1'b0, "hold_c3");
    step(8'h08, 1'b1, 8'h08, 3'd3, 1'b0, "hold_c4");
    step(8'h08, 1'b1, 8'h00, 3'd0, 1'b1, "forced_timeout");
    step(8'h08, 1'b1, 8'h08, 3'd3, 1'b0, "regrant_after_timeout");
    // Drop exactly in the 4th granted cycle: normal release, no timeout.
    step(8'h08, 1'b1, 8'h08, 3'd3, 1'b0, "edge_c2");
    step(8'h08, 1'b1, 8'h08, 3'd3, 1'b0, "edge_c3");
    step(8'h08, 1'b1, 8'h08, 3'd3, 1'b0, "edge_c4");
    step(8'h00, 1'b1, 8'h00, 3'd0, 1'b0, "drop_at_max_no_timeout");
    step(8'h00, 1'b1, 8'h00, 3'd0, 1'b0, "idle_after_drop");

    // ptr=4 now; grant requester 5 and reset it mid-grant.
    step(8'h20, 1'b1, 8'h20, 3'd5, 1'b0, "grant5");
    step(8'h20, 1'b1, 8'h20, 3'd5, 1'b0, "hold5");
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("async_reset_midgrant", {gnt, gnt_id, gnt_vld, timeout}, 13'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(8'hFF, 1'b1, 8'h01, 3'd0, 1'b0, "post_reset_grant0");
    step(8'h00, 1'b1, 8'h00, 3'd0, 1'b0, "post_reset_release");

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
    end
    @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
